// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data memory responder.
// Contents:
//   addr_t, data_t, mask_t   - core memory port payload types
//   mem_resp_state_e         - responder FSM states
//   byte_merge()             - byte-masked word merge used by the RAM write path
//   addr_is_bad()            - misaligned / out-of-range address test used when the
//                              MEM_RESP_ERR_EN build option is defined
package data_mem_responder_pkg;

    typedef logic [63:0] addr_t;
    typedef logic [63:0] data_t;
    typedef logic [7:0]  mask_t;

    typedef enum logic [1:0] {
        MRS_IDLE = 2'd0,
        MRS_BUSY = 2'd1,
        MRS_RESP = 2'd2
    } mem_resp_state_e;

    // Replace only the bytes of old_word whose enable bit is set.
    function automatic data_t byte_merge(input data_t old_word,
                                         input data_t new_word,
                                         input mask_t mask);
        data_t merged;
        merged = old_word;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

    // An address is bad when it is not 8-byte aligned or lies at or beyond
    // 2**(word_bits+3) bytes, i.e. beyond the end of a power-of-two RAM.
    function automatic logic addr_is_bad(input addr_t addr,
                                         input int unsigned word_bits);
        return ((addr >> (word_bits + 32'd3)) != 64'd0) || (addr[2:0] != 3'd0);
    endfunction

endpackage

// File: rtl/data_mem_responder_mask_ram.sv
// Single-port synchronous RAM of 64-bit words with per-byte write enables.
// Ports:
//   clk, rstn    - clock / async active-low reset (resets only the read register)
//   en           - port enable for this cycle
//   we           - 1 = write (masked), 0 = read
//   addr         - word index
//   wdata, wmask - write data and byte enables
//   rdata        - read register; loads mem[addr] on a read, clears to 0 on a
//                  write, and holds otherwise
// The array itself is never reset.
module mask_ram
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  data_t         wdata,
    input  mask_t         wmask,
    output data_t         rdata
);

    data_t mem_r [DEPTH];
    data_t rdata_r;

    // Byte-masked write into the storage array.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem_r[addr] <= byte_merge(mem_r[addr], wdata, wmask);
        end
    end

    // Read register: captures the word on a read, zero on a write, holds when idle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_r <= 64'd0;
        end else if (en) begin
            rdata_r <= we ? 64'd0 : mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core data port: one outstanding load/store,
// byte-masked writes into an internal RAM, response after LATENCY cycles.
// Build option: MEM_RESP_ERR_EN adds mem_resp_err and flags (and suppresses)
// misaligned or out-of-range requests; without it addresses wrap modulo
// DEPTH*8 and address bits [2:0] are ignored.
// Ports:
//   clk, rstn                          - clock, async active-low reset
//   mem_req_valid / mem_req_ready      - request handshake
//   mem_req_addr, mem_req_wen,
//   mem_req_wdata, mem_req_wmask       - request payload (sampled at acceptance)
//   mem_resp_valid / mem_resp_ready    - response handshake
//   mem_resp_rdata                     - load data, 0 for stores
//   mem_resp_err (MEM_RESP_ERR_EN)     - bad-address flag, valid with mem_resp_valid
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 2
) (
    input  logic  clk,
    input  logic  rstn,
    input  logic  mem_req_valid,
    output logic  mem_req_ready,
    input  addr_t mem_req_addr,
    input  logic  mem_req_wen,
    input  data_t mem_req_wdata,
    input  mask_t mem_req_wmask,
    output logic  mem_resp_valid,
    input  logic  mem_resp_ready,
`ifdef MEM_RESP_ERR_EN
    output logic  mem_resp_err,
`endif
    output data_t mem_resp_rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);
    localparam logic          MULTI_CYCLE = (LATENCY > 1) ? 1'b1 : 1'b0;

    mem_resp_state_e state_r, state_next_s;
    logic [CW-1:0]   cnt_r, cnt_next_s;
    logic            accept_s;
    logic            bad_s;
    logic            ready_r;
    logic            resp_valid_r;
    logic            ram_we_s;
    mask_t           ram_mask_s;
    data_t           ram_rdata_s;

`ifdef MEM_RESP_ERR_EN
    logic err_r;
    assign bad_s = addr_is_bad(mem_req_addr, AW);
`else
    // Bits outside the word index are intentionally ignored in this build.
    logic unused_addr_s;
    assign unused_addr_s = ^{mem_req_addr[63:AW+3], mem_req_addr[2:0]};
    assign bad_s = 1'b0;
`endif

    // Next-state and latency counter logic.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        accept_s     = 1'b0;
        case (state_r)
            MRS_IDLE: begin
                if (mem_req_valid) begin
                    accept_s = 1'b1;
                    if (MULTI_CYCLE) begin
                        state_next_s = MRS_BUSY;
                        cnt_next_s   = CW'(1);
                    end else begin
                        state_next_s = MRS_RESP;
                        cnt_next_s   = CW'(0);
                    end
                end else begin
                    state_next_s = MRS_IDLE;
                end
            end
            MRS_BUSY: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = MRS_RESP;
                    cnt_next_s   = CW'(0);
                end else begin
                    cnt_next_s   = cnt_r + CW'(1);
                end
            end
            MRS_RESP: begin
                if (mem_resp_ready) begin
                    state_next_s = MRS_IDLE;
                end else begin
                    state_next_s = MRS_RESP;
                end
            end
            default: begin
                state_next_s = MRS_IDLE;
                cnt_next_s   = CW'(0);
            end
        endcase
    end

    // A bad request is issued to the RAM as an empty-mask write: nothing is
    // stored and the read register clears, which yields rdata=0.
    always_comb begin
        ram_we_s   = mem_req_wen | bad_s;
        if (bad_s) begin
            ram_mask_s = 8'h00;
        end else begin
            ram_mask_s = mem_req_wmask;
        end
    end

    // State, counter and handshake outputs; outputs are registered from the next state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= MRS_IDLE;
            cnt_r        <= CW'(0);
            ready_r      <= 1'b1;
            resp_valid_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            cnt_r        <= cnt_next_s;
            ready_r      <= (state_next_s == MRS_IDLE);
            resp_valid_r <= (state_next_s == MRS_RESP);
        end
    end

`ifdef MEM_RESP_ERR_EN
    // Error flag captured at acceptance, held until the next acceptance.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_r <= 1'b0;
        end else if (accept_s) begin
            err_r <= bad_s;
        end
    end
    assign mem_resp_err = err_r;
`endif

    // The RAM read register doubles as the response data register: it only
    // changes at acceptance, so it is stable for the whole response phase.
    mask_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rstn  (rstn),
        .en    (accept_s),
        .we    (ram_we_s),
        .addr  (mem_req_addr[3 +: AW]),
        .wdata (mem_req_wdata),
        .wmask (ram_mask_s),
        .rdata (ram_rdata_s)
    );

    assign mem_req_ready  = ready_r;
    assign mem_resp_valid = resp_valid_r;
    assign mem_resp_rdata = ram_rdata_s;

endmodule
